// File: rtl/sprite_mover.sv
// Clears the VGA frame, draws a sprite from a 1-cycle-latency colour ROM at home,
// then erases/moves/redraws it left or right with edge clamping. Optional macro: TRANSPARENT_EN.
module sprite_mover #(
   parameter int SPR_W    = 11,
   parameter int SPR_H    = 10,
   parameter int STEP     = 5,
   parameter int X_START  = 73,
   parameter int Y_START  = 105,
   parameter int X_PIXELS = 160,
   parameter int Y_PIXELS = 120,
   parameter int ADDR_W   = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              left,
   input  logic              right,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [2:0]        rom_q,
   output logic [7:0]        xout,
   output logic [6:0]        yout,
   output logic [2:0]        colourOut,
   output logic              drawEn,
   output logic              screenCleared,
   output logic              drewHomeBase,
   output logic              move_done,
   output logic              blocked,
   output logic [7:0]        pos_x,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_TITLE, S_CLEAR, S_HOME, S_READY, S_ERASE, S_UPDATE, S_DRAW, S_DONE
   } state_t;

   localparam logic [7:0] X_LAST   = 8'(X_PIXELS - 1);
   localparam logic [6:0] Y_LAST   = 7'(Y_PIXELS - 1);
   localparam logic [7:0] COL_LAST = 8'(SPR_W - 1);
   localparam logic [6:0] ROW_LAST = 7'(SPR_H - 1);
   localparam logic [6:0] ROW_END  = 7'(SPR_H);
   localparam logic [6:0] Y_BASE   = 7'(Y_START);
   localparam logic [7:0] STEP8    = 8'(STEP);
   localparam logic [8:0] STEP9    = 9'(STEP);
   localparam logic [8:0] X_MAX9   = 9'(X_PIXELS - SPR_W);
   localparam logic [7:0] X_MAX8   = 8'(X_PIXELS - SPR_W);

   state_t            state_q, state_d;
   logic [7:0]        col_q, col_d;
   logic [6:0]        row_q, row_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              dval_q, dval_d;
   logic [7:0]        dcol_q, dcol_d;
   logic [6:0]        drow_q, drow_d;
   logic [7:0]        pos_x_q, pos_x_d;
   logic [7:0]        target_q, target_d;
   logic              blocked_q, blocked_d;
   logic              cleared_q, cleared_d;
   logic [7:0]        tgt;
   logic              right_ok;

   // Valid/ready: left/right are sampled only in READY; move_done is a one-cycle
   // strobe and blocked is meaningful only while move_done is high.
   always_comb begin
      right_ok = (({1'b0, pos_x_q} + STEP9) <= X_MAX9);
      if (left) tgt = (pos_x_q >= STEP8) ? (pos_x_q - STEP8) : 8'd0;
      else      tgt = right_ok ? (pos_x_q + STEP8) : X_MAX8;
   end

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      addr_d       = addr_q;
      dval_d       = 1'b0;
      dcol_d       = col_q;
      drow_d       = row_q;
      pos_x_d      = pos_x_q;
      target_d     = target_q;
      blocked_d    = blocked_q;
      cleared_d    = cleared_q;
      drawEn       = 1'b0;
      xout         = 8'd0;
      yout         = 7'd0;
      colourOut    = 3'd0;
      drewHomeBase = 1'b0;
      move_done    = 1'b0;
      blocked      = 1'b0;

      case (state_q)
         S_TITLE: begin
            col_d  = 8'd0;
            row_d  = 7'd0;
            addr_d = '0;
            if (start) state_d = S_CLEAR;
         end

         S_CLEAR: begin
            drawEn = 1'b1;
            xout   = col_q;
            yout   = row_q;
            if (col_q == X_LAST) begin
               col_d = 8'd0;
               if (row_q == Y_LAST) begin
                  row_d     = 7'd0;
                  cleared_d = 1'b1;
                  state_d   = S_HOME;
               end else begin
                  row_d = row_q + 7'd1;
               end
            end else begin
               col_d = col_q + 8'd1;
            end
         end

         S_HOME, S_DRAW: begin
            // Fetch stage issues one address per cycle; the plot stage trails by one.
            if (row_q != ROW_END) begin
               dval_d = 1'b1;
               addr_d = addr_q + 1'b1;
               if (col_q == COL_LAST) begin
                  col_d = 8'd0;
                  row_d = row_q + 7'd1;
               end else begin
                  col_d = col_q + 8'd1;
               end
            end
            if (dval_q) begin
`ifdef TRANSPARENT_EN
               drawEn = (rom_q != 3'b000);
`else
               drawEn = 1'b1;
`endif
               colourOut = rom_q;
               xout      = pos_x_q + dcol_q;
               yout      = Y_BASE + drow_q;
            end
            if (row_q == ROW_END) begin
               col_d  = 8'd0;
               row_d  = 7'd0;
               addr_d = '0;
               if (state_q == S_HOME) begin
                  drewHomeBase = 1'b1;
                  state_d      = S_READY;
               end else begin
                  state_d = S_DONE;
               end
            end
         end

         S_READY: begin
            if (left ^ right) begin
               target_d  = tgt;
               blocked_d = (tgt == pos_x_q);
               state_d   = (tgt == pos_x_q) ? S_DONE : S_ERASE;
            end
         end

         S_ERASE: begin
            drawEn = 1'b1;
            xout   = pos_x_q + col_q;
            yout   = Y_BASE + row_q;
            if (col_q == COL_LAST) begin
               col_d = 8'd0;
               if (row_q == ROW_LAST) begin
                  row_d   = 7'd0;
                  state_d = S_UPDATE;
               end else begin
                  row_d = row_q + 7'd1;
               end
            end else begin
               col_d = col_q + 8'd1;
            end
         end

         S_UPDATE: begin
            pos_x_d = target_q;
            state_d = S_DRAW;
         end

         S_DONE: begin
            move_done = 1'b1;
            blocked   = blocked_q;
            state_d   = S_READY;
         end

         default: state_d = S_TITLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_TITLE;
         col_q     <= 8'd0;
         row_q     <= 7'd0;
         addr_q    <= '0;
         dval_q    <= 1'b0;
         dcol_q    <= 8'd0;
         drow_q    <= 7'd0;
         pos_x_q   <= 8'(X_START);
         target_q  <= 8'd0;
         blocked_q <= 1'b0;
         cleared_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         addr_q    <= addr_d;
         dval_q    <= dval_d;
         dcol_q    <= dcol_d;
         drow_q    <= drow_d;
         pos_x_q   <= pos_x_d;
         target_q  <= target_d;
         blocked_q <= blocked_d;
         cleared_q <= cleared_d;
      end
   end

   assign rom_addr      = addr_q;
   assign screenCleared = cleared_q;
   assign pos_x         = pos_x_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: a pixel-level reference model fills expected
// queues; a negedge monitor pops and compares every plot strobe and move_done.
module tb_sprite_mover;

   localparam int SPR_W    = 11;
   localparam int SPR_H    = 10;
   localparam int STEP     = 5;
   localparam int X_START  = 73;
   localparam int Y_START  = 105;
   localparam int X_PIXELS = 160;
   localparam int Y_PIXELS = 120;
   localparam int ADDR_W   = 7;

   logic              clk;
   logic              reset;
   logic              start;
   logic              left;
   logic              right;
   logic [ADDR_W-1:0] rom_addr;
   logic [2:0]        rom_q;
   logic [7:0]        xout;
   logic [6:0]        yout;
   logic [2:0]        colourOut;
   logic              drawEn;
   logic              screenCleared;
   logic              drewHomeBase;
   logic              move_done;
   logic              blocked;
   logic [7:0]        pos_x;
   logic [2:0]        state_dbg;

   sprite_mover #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .STEP(STEP), .X_START(X_START), .Y_START(Y_START),
      .X_PIXELS(X_PIXELS), .Y_PIXELS(Y_PIXELS), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .left(left), .right(right),
      .rom_addr(rom_addr), .rom_q(rom_q), .xout(xout), .yout(yout),
      .colourOut(colourOut), .drawEn(drawEn), .screenCleared(screenCleared),
      .drewHomeBase(drewHomeBase), .move_done(move_done), .blocked(blocked),
      .pos_x(pos_x), .state_dbg(state_dbg)
   );

   // clock / synchronous colour ROM
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rom_mem [0:(1<<ADDR_W)-1];
   always @(posedge clk) rom_q <= rom_mem[rom_addr];

   // scoreboard state
   logic [17:0] exp_q[$];
   logic [8:0]  done_q[$];
   int n_cmp, n_err, n_strobes, n_done, n_home, n_pushed, model_x;
   bit mon_en;
   logic [17:0] mon_e;
   logic [8:0]  mon_d;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: event not seen within cycle budget", name);
   endtask

   // reference model
   task automatic push_pix(input int x, input int y, input int c);
      exp_q.push_back({8'(x), 7'(y), 3'(c)});
      n_pushed++;
   endtask

   task automatic push_clear();
      for (int y = 0; y < Y_PIXELS; y++)
         for (int x = 0; x < X_PIXELS; x++)
            push_pix(x, y, 0);
   endtask

   task automatic push_box(input int px, input bit erase);
      int c;
      for (int r = 0; r < SPR_H; r++)
         for (int k = 0; k < SPR_W; k++) begin
            c = erase ? 0 : int'(rom_mem[r*SPR_W + k]);
`ifdef TRANSPARENT_EN
            if (!erase && c == 0) continue;
`endif
            push_pix(px + k, Y_START + r, c);
         end
   endtask

   function automatic int target_of(input int px, input bit go_left);
      int t;
      if (go_left) begin
         t = px - STEP;
         if (t < 0) t = 0;
      end else begin
         t = px + STEP;
         if (t > X_PIXELS - SPR_W) t = X_PIXELS - SPR_W;
      end
      return t;
   endfunction

   task automatic model_move(input bit go_left);
      int t;
      t = target_of(model_x, go_left);
      if (t != model_x) begin
         push_box(model_x, 1'b1);
         push_box(t, 1'b0);
         done_q.push_back({1'b0, 8'(t)});
         model_x = t;
      end else begin
         done_q.push_back({1'b1, 8'(model_x)});
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if (drawEn) begin
            n_strobes++;
            if (exp_q.size() == 0) check("spurious_strobe", drawEn, 0);
            else begin
               mon_e = exp_q.pop_front();
               n_cmp++;
               if ({xout, yout, colourOut} !== mon_e) begin
                  n_err++;
                  $display("FAIL strobe: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                           xout, yout, colourOut, mon_e[17:10], mon_e[9:3], mon_e[2:0]);
               end
            end
         end
         if (move_done) begin
            n_done++;
            if (done_q.size() == 0) check("spurious_move_done", move_done, 0);
            else begin
               mon_d = done_q.pop_front();
               n_cmp++;
               if ({blocked, pos_x} !== mon_d) begin
                  n_err++;
                  $display("FAIL move_done: got blocked=%0d pos_x=%0d, expected blocked=%0d pos_x=%0d",
                           blocked, pos_x, mon_d[8], mon_d[7:0]);
               end
            end
         end
         if (blocked && !move_done) check("blocked_without_done", blocked, 0);
         if (drewHomeBase) n_home++;
      end
   end

   // drivers
   task automatic wait_done();
      int k;
      for (k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (move_done) break;
      end
      if (k == 2000) timeout("move_done_wait");
   endtask

   task automatic do_moves(input bit go_left, input int n);
      for (int i = 0; i < n; i++) model_move(go_left);
      @(negedge clk);
      left  = go_left;
      right = !go_left;
      for (int i = 0; i < n; i++) wait_done();
      left  = 1'b0;
      right = 1'b0;
   endtask

   initial begin
      int k, base_s, base_d;
      reset = 1'b0; start = 1'b0; left = 1'b0; right = 1'b0;
      mon_en = 1'b0; model_x = X_START;
      n_cmp = 0; n_err = 0; n_strobes = 0; n_done = 0; n_home = 0; n_pushed = 0;
      for (int i = 0; i < (1<<ADDR_W); i++) rom_mem[i] = 3'($urandom_range(0, 7));
      rom_mem[4] = 3'd0;

      #23;
      check("rst_drawEn", drawEn, 0);
      check("rst_screenCleared", screenCleared, 0);
      check("rst_pos_x", pos_x, X_START);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_move_done", move_done, 0);
      check("rst_blocked", blocked, 0);
      check("rst_drewHomeBase", drewHomeBase, 0);
      check("rst_xy", {xout, yout}, 0);
      check("rst_colour", colourOut, 0);

      @(negedge clk);
      reset  = 1'b1;
      mon_en = 1'b1;
      repeat (10) @(negedge clk);
      check("title_idle_strobes", n_strobes, 0);

      // frame clear followed by home draw
      push_clear();
      push_box(X_START, 1'b0);
      start = 1'b1;
      for (k = 0; k < X_PIXELS*Y_PIXELS + 100; k++) begin
         @(negedge clk); #1;
         if (n_strobes == X_PIXELS*Y_PIXELS) break;
      end
      if (k == X_PIXELS*Y_PIXELS + 100) timeout("clear_wait");
      check("clear_last_cleared_low", screenCleared, 0);
      check("clear_last_x", xout, X_PIXELS - 1);
      check("clear_last_y", yout, Y_PIXELS - 1);
      start = 1'b0;
      @(negedge clk); #1;
      check("screenCleared_after_clear", screenCleared, 1);
      check("home_first_cycle_no_strobe", drawEn, 0);
      for (k = 0; k < 500; k++) begin
         @(negedge clk);
         if (drewHomeBase) break;
      end
      if (k == 500) timeout("home_wait");
      #1;
      check("home_queue_drained", exp_q.size(), 0);
      check("home_strobe_total", n_strobes, n_pushed);
      check("home_pos_x", pos_x, X_START);

      // directed moves and edge clamping
      do_moves(1'b0, 1);
      #1 check("pos_after_right", pos_x, 78);
      do_moves(1'b1, 15);
      #1 check("pos_at_3", pos_x, 3);
      do_moves(1'b1, 1);
      #1 check("pos_clamped_0", pos_x, 0);
      base_s = n_strobes;
      do_moves(1'b1, 1);
      #1 check("blocked_left_no_strobes", n_strobes, base_s);

      // both keys together must be ignored
      base_s = n_strobes;
      base_d = n_done;
      @(negedge clk);
      left = 1'b1; right = 1'b1;
      repeat (20) @(negedge clk);
      left = 1'b0; right = 1'b0;
      #1;
      check("both_keys_strobes", n_strobes, base_s);
      check("both_keys_done", n_done, base_d);
      check("both_keys_pos", pos_x, 0);

      // random held-key bursts
      for (int i = 0; i < 12; i++)
         do_moves(1'($urandom_range(0, 1)), $urandom_range(1, 3));
      #1 check("random_pos_matches_model", pos_x, model_x);

      do_moves(1'b0, 32);
      #1 check("pos_clamped_right", pos_x, X_PIXELS - SPR_W);
      base_s = n_strobes;
      do_moves(1'b0, 1);
      #1 check("blocked_right_no_strobes", n_strobes, base_s);
      check("moves_queue_drained", exp_q.size() + done_q.size(), 0);
      check("home_pulse_once", n_home, 1);

      // reset in the middle of the redraw
      base_s = n_strobes;
      model_move(1'b1);
      @(negedge clk);
      left = 1'b1;
      for (k = 0; k < 1000; k++) begin
         @(negedge clk); #1;
         if (n_strobes >= base_s + SPR_W*SPR_H + 40) break;
      end
      if (k == 1000) timeout("mid_draw_wait");
      mon_en = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("midrst_drawEn", drawEn, 0);
      check("midrst_screenCleared", screenCleared, 0);
      check("midrst_pos_x", pos_x, X_START);
      check("midrst_move_done", move_done, 0);
      exp_q.delete();
      done_q.delete();
      left = 1'b0;
      @(negedge clk);
      reset  = 1'b1;
      mon_en = 1'b1;
      base_s = n_strobes;
      repeat (30) @(negedge clk);
      #1;
      check("title_after_reset_strobes", n_strobes, base_s);
      check("title_after_reset_cleared", screenCleared, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
